tlb_op_ctrl: RTL
================

TLB_OP_CTRL -- requirements
Module: tlb_op_ctrl

Interface
REQ-001 Parameter TLBNUM, default 16, number of TLB entries; index width IDXW = log2(TLBNUM).
REQ-002 clk  in  1  clock, all state updates on rising edge.
REQ-003 resetn  in  1  asynchronous, active-low reset.
REQ-004 op_valid / op_ready  in / out  1 / 1  TLB-instruction handshake from the WB stage; transfer when both are high.
REQ-005 op_code  in  3  0 = SRCH, 1 = RD, 2 = WR, 3 = FILL, 4 = INV; 5..7 are reserved.
REQ-006 inv_op / inv_asid / inv_va  in  5 / 10 / 19  INVTLB operands, sampled on accept.
REQ-007 csr_vppn / csr_asid / csr_index / csr_ne / csr_ecode  in  19 / 10 / IDXW / 1 / 6  current CSR fields: TLBEHI.VPPN, ASID.ASID, TLBIDX.Index, TLBIDX.NE, ESTAT.Ecode.
REQ-008 s_vppn / s_asid  out  19 / 10  TLB search key; s_found / s_index  in  1 / IDXW  search result.
REQ-009 r_index  out  IDXW  TLB read index; r_e  in  1  and  r_data  in  TLB_RD_WD  read entry.
REQ-010 w_en / w_index / w_e  out  1 / IDXW / 1  TLB write strobe, target entry and E bit.
REQ-011 inv_en / inv_op_o / inv_asid_o / inv_va_o  out  1 / 5 / 10 / 19  TLB invalidate command.
REQ-012 tlbsrh_to_csr_bus  out  2+IDXW  {wen, ne, index}; tlbrd_to_csr_bus  out  1+1+TLB_RD_WD  {wen, e, data}.
REQ-013 busy / done / refetch / op_err  out  1 each  stall request, completion pulse, pipeline refetch request, illegal-operation flag.

Function
REQ-014 The FSM SHALL have the states IDLE, SRCH, RD, WR, INV and DONE; op_ready SHALL be 1 only in IDLE, and busy SHALL equal ~IDLE.
REQ-015 On accept in IDLE, the op_code and operands SHALL be registered, and the FSM SHALL go to SRCH, RD, WR (FILL uses WR), INV, or, for reserved codes, DONE with op_err set.
REQ-016 SRCH: s_vppn/s_asid SHALL be driven from the registered copies; in the next cycle a one-cycle tlbsrh wen SHALL be issued with ne = ~s_found and index = s_index; then the FSM SHALL go to DONE.
REQ-017 RD: r_index SHALL equal the registered csr_index; in the next cycle a one-cycle tlbrd wen SHALL be issued with e = r_e and the r_data value; then the FSM SHALL go to DONE.
REQ-018 WR: w_en SHALL be high for exactly one cycle. For WR, w_index SHALL be csr_index. For FILL, w_index SHALL be fill_ptr captured at accept. w_e SHALL be (csr_ecode == 6'h3F) | ~csr_ne.
REQ-019 fill_ptr SHALL be a free-running IDXW-bit counter incremented every cycle, wrapping TLBNUM-1 -> 0.
REQ-020 INV: if inv_op <= 6, inv_en SHALL pulse for one cycle with the operands. If inv_op > 6, there SHALL be no inv_en and op_err SHALL be set. In both cases the FSM SHALL go to DONE.
REQ-021 DONE SHALL last one cycle: done = 1; refetch = 1 for RD, WR, FILL and INV, and 0 for SRCH; op_err SHALL be valid with done. Then the FSM SHALL return to IDLE.
REQ-022 Latency from accept to done SHALL be 3 cycles for SRCH/RD, 2 cycles for WR/FILL/INV, and 1 cycle for reserved codes; back-to-back accept SHALL be possible in the cycle after DONE.
REQ-023 op_valid outside IDLE SHALL be ignored, and operands SHALL NOT be re-sampled mid-operation.
REQ-024 At most one of the wen/w_en/inv_en strobes SHALL be high in any cycle.

Reset
REQ-025 On resetn low, the following SHALL hold immediately and asynchronously: state = IDLE, fill_ptr = 0, all strobes/done/refetch/op_err = 0, busy = 0, and op_ready SHALL be 1 after release.
REQ-026 Reset mid-operation SHALL abort without issuing any pending strobe.

Structure
REQ-027 The op_code encodings, the FSM state encoding, TLB_RD_WD and the bus widths SHALL be defined in the shared mycpu.h header.
REQ-028 fill_ptr SHALL be a sub-module, tlb_fill_ctr; the rest SHALL be flat.

Verification
REQ-029 SRCH, csr_vppn = 0x12345, s_found = 1, s_index = 5 -> tlbsrh bus {1,0,5} 2 cycles after accept; done at +3; refetch = 0.
REQ-030 RD, csr_index = 3, r_e = 0 -> r_index = 3; tlbrd wen with e = 0; done with refetch = 1.
REQ-031 FILL accepted when fill_ptr = 15, with csr_ecode = 0x3F and csr_ne = 1 -> w_en, w_index = 15, w_e = 1; the counter wraps to 0.
REQ-032 INV, inv_op = 7 -> no inv_en; done with op_err = 1. INV, inv_op = 5 -> inv_en pulse; op_err = 0.
REQ-033 resetn asserted during the RD second cycle -> no tlbrd wen; state = IDLE; op_ready = 1 after release.
REQ-034 op_valid held high continuously -> an accept occurs every (latency + 1) cycles, with no strobe overlap.

Source files
------------

// File: rtl/tlb_op_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tlb_op_ctrl_pkg
// Description : Shared TLB-instruction encodings, FSM states and bus widths
// Revision    : 1.0 - initial release
// ============================================================================
package tlb_op_ctrl_pkg;

  // Width of one TLB entry as returned by a TLB read
  localparam int TLB_RD_WD    = 64;
  // tlbrd bus = {wen, e, data}
  localparam int TLBRD_BUS_WD = 2 + TLB_RD_WD;

  // TLB instruction op_code encodings; 5..7 are reserved
  localparam logic [2:0] C_OP_SRCH = 3'd0;
  localparam logic [2:0] C_OP_RD   = 3'd1;
  localparam logic [2:0] C_OP_WR   = 3'd2;
  localparam logic [2:0] C_OP_FILL = 3'd3;
  localparam logic [2:0] C_OP_INV  = 3'd4;

  // Largest legal INVTLB op value
  localparam logic [4:0] C_INV_OP_MAX = 5'd6;
  // ESTAT.Ecode value marking a TLB refill exception
  localparam logic [5:0] C_ECODE_TLBR = 6'h3F;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SRCH = 3'd1,
    ST_RD   = 3'd2,
    ST_WR   = 3'd3,
    ST_INV  = 3'd4,
    ST_DONE = 3'd5
  } state_e;

  // tlbsrh bus = {wen, ne, index}
  function automatic int tlbsrh_bus_wd(input int idxw);
    return 2 + idxw;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tlb_op_ctrl_fill_ctr.sv
`default_nettype none
// ============================================================================
// Module      : tlb_fill_ctr
// Description : Free-running TLBFILL victim pointer, wraps TLBNUM-1 -> 0
// Revision    : 1.0 - initial release
// ============================================================================
module tlb_fill_ctr #(
  parameter  int TLBNUM = 16,
  localparam int IDXW   = $clog2(TLBNUM)
) (
  input  logic            clk,
  input  logic            resetn,
  output logic [IDXW-1:0] o_fill_ptr
);

  logic [IDXW-1:0] r_ptr;

  // Advance every cycle; explicit wrap keeps non-power-of-two TLBNUM legal
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_ptr <= '0;
    end else if (r_ptr == IDXW'(TLBNUM - 1)) begin
      r_ptr <= '0;
    end else begin
      r_ptr <= r_ptr + IDXW'(1);
    end
  end

  assign o_fill_ptr = r_ptr;

endmodule
`default_nettype wire

// File: rtl/tlb_op_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tlb_op_ctrl
// Description : Sequencer for TLBSRCH/TLBRD/TLBWR/TLBFILL/INVTLB from WB
// Revision    : 1.0 - initial release
// ============================================================================
module tlb_op_ctrl
  import tlb_op_ctrl_pkg::*;
#(
  parameter  int TLBNUM = 16,
  localparam int IDXW   = $clog2(TLBNUM)
) (
  input  logic                     clk,
  input  logic                     resetn,
  // instruction handshake
  input  logic                     op_valid,
  output logic                     op_ready,
  input  logic [2:0]               op_code,
  input  logic [4:0]               inv_op,
  input  logic [9:0]               inv_asid,
  input  logic [18:0]              inv_va,
  // CSR fields
  input  logic [18:0]              csr_vppn,
  input  logic [9:0]               csr_asid,
  input  logic [IDXW-1:0]          csr_index,
  input  logic                     csr_ne,
  input  logic [5:0]               csr_ecode,
  // search port
  output logic [18:0]              s_vppn,
  output logic [9:0]               s_asid,
  input  logic                     s_found,
  input  logic [IDXW-1:0]          s_index,
  // read port
  output logic [IDXW-1:0]          r_index,
  input  logic                     r_e,
  input  logic [TLB_RD_WD-1:0]     r_data,
  // write port
  output logic                     w_en,
  output logic [IDXW-1:0]          w_index,
  output logic                     w_e,
  // invalidate port
  output logic                     inv_en,
  output logic [4:0]               inv_op_o,
  output logic [9:0]               inv_asid_o,
  output logic [18:0]              inv_va_o,
  // CSR update buses
  output logic [IDXW+1:0]          tlbsrh_to_csr_bus,
  output logic [TLBRD_BUS_WD-1:0]  tlbrd_to_csr_bus,
  // status
  output logic                     busy,
  output logic                     done,
  output logic                     refetch,
  output logic                     op_err
);

  state_e          r_state;
  state_e          w_state_nxt;
  logic            r_phase;
  logic            w_phase_nxt;

  logic [2:0]      r_op;
  logic [4:0]      r_inv_op;
  logic [9:0]      r_inv_asid;
  logic [18:0]     r_inv_va;
  logic [18:0]     r_csr_vppn;
  logic [9:0]      r_csr_asid;
  logic [IDXW-1:0] r_csr_index;
  logic            r_csr_ne;
  logic [5:0]      r_csr_ecode;
  logic [IDXW-1:0] r_fill_idx;

  logic [IDXW-1:0] w_fill_ptr;
  logic            w_accept;
  logic            w_srh_wen;
  logic            w_rd_wen;
  logic            w_inv_bad;
  logic            w_reserved;
  logic            w_err_op;
  logic            w_refetch_op;

  tlb_fill_ctr #(.TLBNUM(TLBNUM)) u_fill_ctr (
    .clk        (clk),
    .resetn     (resetn),
    .o_fill_ptr (w_fill_ptr)
  );

  assign op_ready = (r_state == ST_IDLE);
  assign busy     = (r_state != ST_IDLE);
  assign w_accept = op_ready & op_valid;

  assign w_inv_bad    = (r_inv_op > C_INV_OP_MAX);
  assign w_reserved   = (r_op > C_OP_INV);
  assign w_err_op     = w_reserved | ((r_op == C_OP_INV) & w_inv_bad);
  assign w_refetch_op = (r_op != C_OP_SRCH) & ~w_reserved;

  // Operands are captured only on accept, so later input changes cannot leak in
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_op        <= '0;
      r_inv_op    <= '0;
      r_inv_asid  <= '0;
      r_inv_va    <= '0;
      r_csr_vppn  <= '0;
      r_csr_asid  <= '0;
      r_csr_index <= '0;
      r_csr_ne    <= 1'b0;
      r_csr_ecode <= '0;
      r_fill_idx  <= '0;
    end else if (w_accept) begin
      r_op        <= op_code;
      r_inv_op    <= inv_op;
      r_inv_asid  <= inv_asid;
      r_inv_va    <= inv_va;
      r_csr_vppn  <= csr_vppn;
      r_csr_asid  <= csr_asid;
      r_csr_index <= csr_index;
      r_csr_ne    <= csr_ne;
      r_csr_ecode <= csr_ecode;
      r_fill_idx  <= w_fill_ptr;
    end
  end

  // State register; r_phase splits SRCH/RD into key cycle and result cycle
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= ST_IDLE;
      r_phase <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_phase <= w_phase_nxt;
    end
  end

  // Next-state and strobe decode; all strobes are Moore outputs of the state
  always_comb begin
    w_state_nxt = r_state;
    w_phase_nxt = 1'b0;
    w_srh_wen   = 1'b0;
    w_rd_wen    = 1'b0;
    w_en        = 1'b0;
    inv_en      = 1'b0;
    done        = 1'b0;
    refetch     = 1'b0;
    op_err      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (op_valid) begin
          case (op_code)
            C_OP_SRCH:           w_state_nxt = ST_SRCH;
            C_OP_RD:             w_state_nxt = ST_RD;
            C_OP_WR, C_OP_FILL:  w_state_nxt = ST_WR;
            C_OP_INV:            w_state_nxt = ST_INV;
            default:             w_state_nxt = ST_DONE;
          endcase
        end
      end
      ST_SRCH: begin
        if (!r_phase) begin
          w_phase_nxt = 1'b1;
        end else begin
          w_srh_wen   = 1'b1;
          w_state_nxt = ST_DONE;
        end
      end
      ST_RD: begin
        if (!r_phase) begin
          w_phase_nxt = 1'b1;
        end else begin
          w_rd_wen    = 1'b1;
          w_state_nxt = ST_DONE;
        end
      end
      ST_WR: begin
        w_en        = 1'b1;
        w_state_nxt = ST_DONE;
      end
      ST_INV: begin
        inv_en      = ~w_inv_bad;
        w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        done        = 1'b1;
        refetch     = w_refetch_op;
        op_err      = w_err_op;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign s_vppn     = r_csr_vppn;
  assign s_asid     = r_csr_asid;
  assign r_index    = r_csr_index;
  assign w_index    = (r_op == C_OP_FILL) ? r_fill_idx : r_csr_index;
  assign w_e        = (r_csr_ecode == C_ECODE_TLBR) | ~r_csr_ne;
  assign inv_op_o   = r_inv_op;
  assign inv_asid_o = r_inv_asid;
  assign inv_va_o   = r_inv_va;

  assign tlbsrh_to_csr_bus = {w_srh_wen, ~s_found, s_index};
  assign tlbrd_to_csr_bus  = {w_rd_wen, r_e, r_data};

endmodule
`default_nettype wire
